// File: rtl/c_cmp_seq.sv
// c_cmp_seq: multi-cycle chunked comparator.
// MSB-first scan with early exit, valid/ready on both sides.
module c_cmp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic             out_lt,
  output logic             out_eq
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("c_cmp_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       op_q;
  logic [CHUNK-1:0] ca, cb;
  logic             fin, lt_c, eq_c;
  logic             accept;

  // MSB inversion maps two's-complement order onto unsigned order
  logic [WIDTH-1:0] flip;
  assign flip = {sgn, {(WIDTH-1){1'b0}}};

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // select the chunk pair under examination
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        ca = a[i*CHUNK +: CHUNK];
        cb = b[i*CHUNK +: CHUNK];
      end
    end
  end

  // next state and per-cycle scan decision
  always_comb begin
    state_d = state;
    idx_d   = idx;
    fin     = 1'b0;
    lt_c    = 1'b0;
    eq_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          idx_d   = IW'(NCH-1);
        end
      end
      SCAN: begin
        if (ca != cb) begin
          fin     = 1'b1;
          lt_c    = (ca < cb);
          state_d = DONE;
        end else if (idx == '0) begin
          fin     = 1'b1;
          eq_c    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, operand capture and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a      <= '0;
      b      <= '0;
      op_q   <= '0;
      out    <= 1'b0;
      out_lt <= 1'b0;
      out_eq <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (accept) begin
        a    <= in0 ^ flip;
        b    <= in1 ^ flip;
        op_q <= op;
      end
      if (fin) begin
        out_lt <= lt_c;
        out_eq <= eq_c;
        unique case (op_q)
          2'b00: out <= eq_c;
          2'b01: out <= lt_c;
          2'b10: out <= !eq_c;
          2'b11: out <= !lt_c;
          default: out <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c_cmp_seq.sv
// tb_c_cmp_seq: directed scoreboard bench for c_cmp_seq.
// Expected results queued at issue, popped at out_valid.
module tb_c_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = '0;
  logic        sgn = 1'b0;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out;
  logic        out_lt;
  logic        out_eq;

  typedef struct packed {
    logic r;
    logic lt;
    logic eq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  c_cmp_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .sgn      (sgn),
    .in0      (in0),
    .in1      (in1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_lt   (out_lt),
    .out_eq   (out_eq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic s,
                                 input logic [15:0] x,
                                 input logic [15:0] y);
    exp_t e;
    e.eq = (x == y);
    e.lt = s ? ($signed(x) < $signed(y)) : (x < y);
    case (o)
      2'b00: e.r = e.eq;
      2'b01: e.r = e.lt;
      2'b10: e.r = !e.eq;
      default: e.r = !e.lt;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [1:0] o, input logic s,
                       input logic [15:0] x, input logic [15:0] y);
    op = o; sgn = s; in0 = x; in1 = y;
    in_valid = 1'b1;
    exp_q.push_back(model(o, s, x, y));
  endtask

  // returns right after the accepting edge (+1)
  task automatic issue(input logic [1:0] o, input logic s,
                       input logic [15:0] x, input logic [15:0] y);
    bit ok = 0;
    drive(o, s, x, y);
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
    in0 = 16'($urandom);
    in1 = 16'($urandom);
    op  = 2'($urandom);
    sgn = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int lat);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, 32'(out), 32'(e.r));
      chk({tag, "_lt"}, 32'(out_lt), 32'(e.lt));
      chk({tag, "_eq"}, 32'(out_eq), 32'(e.eq));
    end else begin
      chk({tag, "_no_result"}, 32'(out_valid), 32'd1);
    end
  endtask

  task automatic handshake(input string tag);
    @(posedge clk); #1;
    chk({tag, "_hs_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_ir"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic s, input logic [15:0] x,
                     input logic [15:0] y, input int lat);
    issue(o, s, x, y);
    wait_result(tag, lat);
    handshake(tag);
  endtask

  initial begin
    logic hr, hl, he;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_ir", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_out", {29'd0, out, out_lt, out_eq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ir", 32'(in_ready), 32'd1);

    run("ult",    2'b01, 1'b0, 16'h0001, 16'h0003, 4);
    run("slt",    2'b01, 1'b1, 16'hFFFF, 16'h0001, 1);
    run("ult_ff", 2'b01, 1'b0, 16'hFFFF, 16'h0001, 1);
    run("eq",     2'b00, 1'b0, 16'hA5A5, 16'hA5A5, 4);
    run("neq_s",  2'b10, 1'b0, 16'hA5A5, 16'hA5A5, 4);
    run("neq_d",  2'b10, 1'b0, 16'h0001, 16'hFFFC, 1);
    run("geq",    2'b11, 1'b0, 16'hFFFF, 16'hFFF0, 4);

    // backpressure with a new request waiting
    out_ready = 1'b0;
    issue(2'b11, 1'b1, 16'h8000, 16'h7FFF);
    wait_result("bp", 1);
    hr = out; hl = out_lt; he = out_eq;
    drive(2'b00, 1'b0, 16'h1234, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_ir", 32'(in_ready), 32'd0);
      chk("bp_hold", {29'd0, out, out_lt, out_eq}, {29'd0, hr, hl, he});
    end
    out_ready = 1'b1;
    handshake("bp");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_acc", 32'(in_ready), 32'd0);
    wait_result("bp2", 4);
    handshake("bp2");

    // reset while scanning
    issue(2'b01, 1'b0, 16'h1234, 16'h1235);
    void'(exp_q.pop_back());
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_ir", 32'(in_ready), 32'd0);
    chk("mrst_out", {29'd0, out, out_lt, out_eq}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("mrst_stale", 32'(out_valid), 32'd0);
    end

    run("post", 2'b01, 1'b1, 16'h0005, 16'hFFFE, 1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
